// File: rtl/sew_unpacker_result.sv
// sew_unpacker_result
// Takes the packed double-width product vector from the SEW-partitioned
// multiplier and turns it into REG_WIDTH-wide writeback words.
//   LOW   : low SEW bits of each product, packed densely
//   HIGH  : high SEW bits of each product, packed densely
//   WIDEN : the full product is emitted as two beats, low half first
// Illegal sew/op_sel values produce one zero beat with err set.
// The output is registered, with valid/ready handshakes on both sides.

module sew_unpacker_result #(
  parameter int REG_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             sew,
  input  logic [1:0]             op_sel,
  input  logic [2*REG_WIDTH-1:0] product_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [REG_WIDTH-1:0]   result_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   err
);

  localparam logic [1:0] SEW_8   = 2'b00;
  localparam logic [1:0] SEW_16  = 2'b01;
  localparam logic [1:0] SEW_32  = 2'b10;
  localparam logic [1:0] OP_LOW  = 2'b00;
  localparam logic [1:0] OP_HIGH = 2'b01;
  localparam logic [1:0] OP_WIDE = 2'b10;

  localparam int N8  = REG_WIDTH / 8;
  localparam int N16 = REG_WIDTH / 16;
  localparam int N32 = REG_WIDTH / 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_HOLD_HI
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  state_t                 w_accept_state;
  logic [REG_WIDTH-1:0]   r_result;
  logic [REG_WIDTH-1:0]   r_beat1;
  logic                   r_last;
  logic                   r_err;

  logic                   w_legal;
  logic                   w_widen;
  logic                   w_high;
  logic                   w_accept;
  logic [REG_WIDTH-1:0]   w_narrow;
  logic [REG_WIDTH-1:0]   w_beat0;

  assign w_legal  = (sew != 2'b11) && (op_sel != 2'b11);
  assign w_widen  = w_legal && (op_sel == OP_WIDE);
  assign w_high   = (op_sel == OP_HIGH);

  assign in_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
  assign w_accept = in_valid && in_ready;

  assign w_accept_state = w_widen ? S_HOLD_HI : S_HOLD;

  // Narrowing selection: pick the low or high SEW bits of each 2*SEW product.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_narrow = '0;
    case (sew)
      SEW_8: begin
        for (int i = 0; i < N8; i++)
          w_narrow[8*i +: 8] = w_high ? product_in[16*i + 8 +: 8]
                                      : product_in[16*i +: 8];
      end
      SEW_16: begin
        for (int i = 0; i < N16; i++)
          w_narrow[16*i +: 16] = w_high ? product_in[32*i + 16 +: 16]
                                        : product_in[32*i +: 16];
      end
      SEW_32: begin
        for (int i = 0; i < N32; i++)
          w_narrow[32*i +: 32] = w_high ? product_in[64*i + 32 +: 32]
                                        : product_in[64*i +: 32];
      end
      default: w_narrow = '0;
    endcase
  end

  // First (or only) beat of an accepted transaction.
  always_comb begin
    w_beat0 = '0;
    if (!w_legal)
      w_beat0 = '0;
    else if (op_sel == OP_WIDE)
      w_beat0 = product_in[REG_WIDTH-1:0];
    else if ((op_sel == OP_LOW) || (op_sel == OP_HIGH))
      w_beat0 = w_narrow;
  end

  // Next-state logic for the output-register FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (in_valid)  w_state_nxt = w_accept_state;
      S_HOLD:    if (out_ready) w_state_nxt = in_valid ? w_accept_state : S_IDLE;
      S_HOLD_HI: if (out_ready) w_state_nxt = S_HOLD;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Output beat register: load on accept, or swap in beat1 when beat0 drains.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_result <= '0;
      r_last   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_result <= w_beat0;
      r_last   <= !w_widen;
      r_err    <= !w_legal;
    end else if ((r_state == S_HOLD_HI) && out_ready) begin
      r_result <= r_beat1;
      r_last   <= 1'b1;
      r_err    <= 1'b0;
    end
  end

  // Upper half of a WIDEN product, parked until beat0 is consumed.
  // NOTE: r_beat1 has no reset; it is only read in HOLD_HI, which is entered solely by the accept that loads it.
  always_ff @(posedge clk) begin
    if (w_accept) r_beat1 <= product_in[2*REG_WIDTH-1:REG_WIDTH];
  end

  assign out_valid  = (r_state != S_IDLE);
  assign result_out = r_result;
  assign out_last   = r_last;
  assign err        = r_err;

endmodule
